io_port_bridge: RTL and testbench
=================================

Name: io_port_bridge

Overview:
- Sits directly downstream of the processor's memory stage: it consumes the stage's 16-bit `write_out` data and produces the stage's 16-bit `read_in` data.
- Decouples the core from an external device through valid/ready handshakes on both directions.
- TX path: a small synchronous FIFO buffers stores from the core.
- RX path: a single-entry holding register with a two-state FSM presents device data to the core until it is consumed.

Parameters:
- DATA_W, 16, data width of both paths.
- TX_DEPTH, 4, number of TX FIFO entries; must be a power of two, at least 2.
- PTR_W, 2, log2(TX_DEPTH).

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_wdata  in  DATA_W  store data from the core (its `write_out`).
- cpu_we  in  1  store strobe; one push per cycle when high.
- cpu_full  out  1  TX FIFO full (count == TX_DEPTH).
- cpu_rdata  out  DATA_W  load data to the core (its `read_in`).
- cpu_rvalid  out  1  cpu_rdata holds unconsumed device data.
- cpu_re  in  1  core consumes cpu_rdata this cycle.
- tx_data  out  DATA_W  head of the TX FIFO.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  device accepts tx_data.
- rx_data  in  DATA_W  device data.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge can accept rx_data.
- tx_count  out  PTR_W+1  current TX FIFO occupancy, 0..TX_DEPTH.
- err  out  2  sticky flags: bit0 = TX overflow, bit1 = RX underflow.
- err_clr  in  1  clears err.

Behaviour:
- Reset (rst high at a clock edge) drives:
  - tx_count = 0, tx_valid = 0, tx_data = 0;
  - RX FSM to EMPTY, cpu_rvalid = 0, cpu_rdata = 0, rx_ready = 1;
  - err = 0.
  - FIFO storage contents are don't-care.
  - Reset overrides every simultaneous event, including a TX transfer in progress.
- TX pop: occurs when tx_valid && tx_ready.
  - The read pointer advances, wrapping modulo TX_DEPTH.
  - tx_data is show-ahead: it always equals the entry at the read pointer, from a combinational read of the storage.
- TX push: cpu_we && (tx_count < TX_DEPTH || pop this cycle).
  - The write pointer advances with wrap.
  - Push and pop in the same cycle leave tx_count unchanged. This holds even when full: the pop frees a slot, so the push is accepted.
- TX overflow: cpu_we while full with no pop.
  - The data is dropped, the FIFO is unchanged and err[0] sets.
- TX latency: a word pushed into an empty FIFO appears on tx_data/tx_valid on the cycle after the push edge.
- Ordering: data leaves in strict FIFO order; no reordering and no duplication.
- RX FSM states: EMPTY, FULL.
  - EMPTY: rx_ready = 1. On rx_valid, capture rx_data into cpu_rdata and go to FULL.
  - FULL: rx_ready = 0, cpu_rvalid = 1. On cpu_re, go to EMPTY.
  - cpu_rdata keeps its last value after EMPTY is re-entered.
- RX throughput: rx_ready is decoded only from the state, with no combinational path from cpu_re. Sustained RX throughput is therefore one word per two cycles; this is accepted.
- RX underflow: cpu_re while EMPTY.
  - err[1] sets and the state is unchanged.
  - cpu_rdata returns its stale value.
- err behaviour:
  - Flags are sticky until err_clr.
  - If err_clr and a new error occur in the same cycle, the error wins and its bit is set.
  - err_clr has no other effect.
- Independence: the TX and RX paths are fully independent; simultaneous activity on both never stalls either.
- Arithmetic: pointers are PTR_W bits wide and wrap naturally; tx_count is PTR_W+1 bits wide so TX_DEPTH is representable.

Decomposition:
- Shared package (io_bridge_pkg):
  - RX state encoding: RX_EMPTY = 1'b0, RX_FULL = 1'b1.
  - Error bit indices: ERR_TX_OVF = 0, ERR_RX_UNF = 1.
  - Default DATA_W and TX_DEPTH constants.
- One sub-module, io_tx_fifo: a generic synchronous show-ahead FIFO with push, pop, full, empty, count and an overflow pulse.
  - The RX register, the RX FSM and the error logic stay in io_port_bridge.

Test Plan:
- Reset then idle: hold rst for 2 cycles with all inputs 0 -> tx_valid = 0, tx_count = 0, rx_ready = 1, cpu_rvalid = 0, err = 00, cpu_rdata = 0x0000.
- TX fill, overflow and drain: tx_ready = 0, push 0x1111, 0x2222, 0x3333, 0x4444, then 0x5555 -> cpu_full = 1 and tx_count = 4 after the fourth push; the fifth push sets err[0]. Then raise tx_ready -> tx_data sequence 0x1111..0x4444 on consecutive cycles, 0x5555 never appears, tx_valid drops after the fourth pop.
- Full with simultaneous push and pop: FIFO full with head 0xAAAA, tx_ready = 1, push 0xBBBB -> tx_count stays 4, err[0] stays 0, next tx_data = second entry, 0xBBBB emerges last.
- RX handshake: rx_valid = 1 with rx_data = 0xBEEF -> next cycle cpu_rvalid = 1, cpu_rdata = 0xBEEF, rx_ready = 0. Change rx_data to 0xCAFE -> no capture. Pulse cpu_re -> rx_ready = 1 next cycle, then 0xCAFE captured.
- Underflow and err_clr: cpu_re while EMPTY -> err[1] = 1, state still EMPTY. err_clr together with a new TX overflow -> err = 01.
- Reset mid-operation: 3 words queued and RX FULL, assert rst for 1 cycle -> tx_count = 0, tx_valid = 0, cpu_rvalid = 0, rx_ready = 1 on the following cycle; no queued word is emitted afterwards.

Source files
------------

// File: rtl/io_bridge_pkg.sv
// Shared constants and encodings for the I/O port bridge.
package io_bridge_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int TX_DEPTH_DEF = 4;

  // RX holding register state
  typedef enum logic {
    RX_EMPTY = 1'b0,
    RX_FULL  = 1'b1
  } rx_state_e;

  // Bit positions inside the sticky error vector
  localparam int ERR_TX_OVF = 0;
  localparam int ERR_RX_UNF = 1;

endpackage

// File: rtl/io_tx_fifo.sv
// Generic synchronous show-ahead FIFO.
// Handshake: a pop happens when pop_i is high and the FIFO is non-empty.
// A push is accepted when push_i is high and there is room, or a pop frees
// a slot in the same cycle. A push that finds no room raises ovf_o for
// that cycle and is dropped.
module io_tx_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o,
  output logic             ovf_o
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Show-ahead: head entry is read combinationally
  assign rdata_o = mem_q[rd_ptr_q];

  // Accept/pop decisions and next pointer/count values
  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    ovf_o    = push_i && full_o && !pop_ok;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; storage cleared so the head reads zero after reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/io_port_bridge.sv
// Bridge between the memory stage and an external device.
// All handshakes are valid/ready: a transfer happens on a rising edge where
// both valid and ready are high. TX: tx_valid/tx_ready. RX: rx_valid/rx_ready
// into a single holding register, presented to the core as cpu_rvalid and
// consumed by cpu_re. rx_ready depends only on the RX state.
module io_port_bridge
  import io_bridge_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TX_DEPTH = TX_DEPTH_DEF,
  localparam int PTR_W   = $clog2(TX_DEPTH)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic              cpu_full,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [PTR_W:0]    tx_count,
  output logic [1:0]        err,
  input  logic              err_clr
);

  logic      tx_empty;
  logic      tx_ovf;
  logic      rx_unf;

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;

  io_tx_fifo #(
    .W     (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clock),
    .rst_i   (rst),
    .push_i  (cpu_we),
    .wdata_i (cpu_wdata),
    .pop_i   (tx_ready),
    .rdata_o (tx_data),
    .full_o  (cpu_full),
    .empty_o (tx_empty),
    .count_o (tx_count),
    .ovf_o   (tx_ovf)
  );

  assign tx_valid   = !tx_empty;
  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = (state_q == RX_FULL);
  assign rx_ready   = (state_q == RX_EMPTY);
  assign err        = err_q;

  // RX FSM next state, capture and underflow detection
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    rx_unf  = 1'b0;
    case (state_q)
      RX_EMPTY: begin
        rx_unf = cpu_re;
        if (rx_valid) begin
          rdata_d = rx_data;
          state_d = RX_FULL;
        end
      end
      RX_FULL: begin
        if (cpu_re) state_d = RX_EMPTY;
      end
      default: state_d = RX_EMPTY;
    endcase
  end

  // Sticky errors: a new error in the clearing cycle still sets its bit
  always_comb begin
    err_d = err_clr ? 2'b00 : err_q;
    if (tx_ovf) err_d[ERR_TX_OVF] = 1'b1;
    if (rx_unf) err_d[ERR_RX_UNF] = 1'b1;
  end

  // RX state, holding register and error flags
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= RX_EMPTY;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge.
module tb_io_port_bridge;

  logic        clock = 1'b0;
  logic        rst;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_full;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_re;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [2:0]  tx_count;
  logic [1:0]  err;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  io_port_bridge dut (
    .clock      (clock),
    .rst        (rst),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_full   (cpu_full),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_re     (cpu_re),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_count   (tx_count),
    .err        (err),
    .err_clr    (err_clr)
  );

  // Clock
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [15:0] wd;
    logic        trdy;
    logic        rxv;
    logic [15:0] rxd;
    logic        re;
    logic        clr;
    logic [2:0]  e_cnt;
    logic        e_full;
    logic        e_valid;
    logic        chk_data;
    logic [15:0] e_data;
    logic        e_rvalid;
    logic [15:0] e_rdata;
    logic        e_rready;
    logic [1:0]  e_err;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic we, logic [15:0] wd, logic trdy, logic rxv,
                              logic [15:0] rxd, logic re, logic clr,
                              logic [2:0] e_cnt, logic e_full, logic e_valid,
                              logic chk_data, logic [15:0] e_data, logic e_rvalid,
                              logic [15:0] e_rdata, logic e_rready, logic [1:0] e_err);
    vec_t v;
    v.we = we; v.wd = wd; v.trdy = trdy; v.rxv = rxv; v.rxd = rxd; v.re = re;
    v.clr = clr; v.e_cnt = e_cnt; v.e_full = e_full; v.e_valid = e_valid;
    v.chk_data = chk_data; v.e_data = e_data; v.e_rvalid = e_rvalid;
    v.e_rdata = e_rdata; v.e_rready = e_rready; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_we = 0; cpu_wdata = '0; cpu_re = 0; tx_ready = 0;
    rx_valid = 0; rx_data = '0; err_clr = 0; rst = 0;
  endtask

  task automatic push_word(input logic [15:0] d);
    cpu_we = 1; cpu_wdata = d; tick(); cpu_we = 0;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    string tag;
    cpu_we = v.we; cpu_wdata = v.wd; tx_ready = v.trdy; rx_valid = v.rxv;
    rx_data = v.rxd; cpu_re = v.re; err_clr = v.clr;
    tick();
    tag = $sformatf("row%0d", idx);
    check({tag, "_tx_count"},   tx_count,   v.e_cnt);
    check({tag, "_cpu_full"},   cpu_full,   v.e_full);
    check({tag, "_tx_valid"},   tx_valid,   v.e_valid);
    if (v.chk_data) check({tag, "_tx_data"}, tx_data, v.e_data);
    check({tag, "_cpu_rvalid"}, cpu_rvalid, v.e_rvalid);
    check({tag, "_cpu_rdata"},  cpu_rdata,  v.e_rdata);
    check({tag, "_rx_ready"},   rx_ready,   v.e_rready);
    check({tag, "_err"},        err,        v.e_err);
  endtask

  // Behavioural reference model state for the random phase
  logic [15:0] m_q[$];
  logic        m_rx_full;
  logic [15:0] m_rdata;
  logic [1:0]  m_err;

  task automatic model_step();
    bit pop, push, ovf, unf;
    pop  = (m_q.size() > 0) && tx_ready;
    ovf  = cpu_we && (m_q.size() == 4) && !pop;
    push = cpu_we && !ovf;
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(cpu_wdata);
    unf = cpu_re && !m_rx_full;
    if (!m_rx_full) begin
      if (rx_valid) begin m_rdata = rx_data; m_rx_full = 1; end
    end else if (cpu_re) begin
      m_rx_full = 0;
    end
    if (err_clr) m_err = 2'b00;
    if (ovf) m_err[0] = 1'b1;
    if (unf) m_err[1] = 1'b1;
  endtask

  initial begin
    idle_inputs();

    // Reset then idle
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst_tx_valid",   tx_valid,   0);
    check("rst_tx_count",   tx_count,   0);
    check("rst_tx_data",    tx_data,    16'h0000);
    check("rst_rx_ready",   rx_ready,   1);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_err",        err,        2'b00);
    check("rst_cpu_rdata",  cpu_rdata,  16'h0000);

    // Table: TX fill/overflow/drain, then RX handshake, underflow, clear
    //             we  wd       trdy rxv rxd      re clr cnt full vld chk data     rv rdata    rrdy err
    tbl[0]  = mk(1, 16'h1111, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 1, 16'h1111, 0, 16'h0000, 1, 2'b00);
    tbl[1]  = mk(1, 16'h2222, 0, 0, 16'h0000, 0, 0, 2, 0, 1, 1, 16'h1111, 0, 16'h0000, 1, 2'b00);
    tbl[2]  = mk(1, 16'h3333, 0, 0, 16'h0000, 0, 0, 3, 0, 1, 1, 16'h1111, 0, 16'h0000, 1, 2'b00);
    tbl[3]  = mk(1, 16'h4444, 0, 0, 16'h0000, 0, 0, 4, 1, 1, 1, 16'h1111, 0, 16'h0000, 1, 2'b00);
    tbl[4]  = mk(1, 16'h5555, 0, 0, 16'h0000, 0, 0, 4, 1, 1, 1, 16'h1111, 0, 16'h0000, 1, 2'b01);
    tbl[5]  = mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 3, 0, 1, 1, 16'h2222, 0, 16'h0000, 1, 2'b01);
    tbl[6]  = mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 2, 0, 1, 1, 16'h3333, 0, 16'h0000, 1, 2'b01);
    tbl[7]  = mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1, 0, 1, 1, 16'h4444, 0, 16'h0000, 1, 2'b01);
    tbl[8]  = mk(0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 2'b00);
    tbl[9]  = mk(0, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'hBEEF, 0, 2'b00);
    tbl[10] = mk(0, 16'h0000, 0, 1, 16'hCAFE, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'hBEEF, 0, 2'b00);
    tbl[11] = mk(0, 16'h0000, 0, 1, 16'hCAFE, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 16'hBEEF, 1, 2'b00);
    tbl[12] = mk(0, 16'h0000, 0, 1, 16'hCAFE, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'hCAFE, 0, 2'b00);
    tbl[13] = mk(0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 16'hCAFE, 1, 2'b00);
    tbl[14] = mk(0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 16'hCAFE, 1, 2'b10);
    tbl[15] = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'hCAFE, 1, 2'b00);
    for (int i = 0; i < 16; i++) apply_vec(i, tbl[i]);
    idle_inputs();

    // Full FIFO with simultaneous push and pop
    push_word(16'hAAAA); push_word(16'h0001); push_word(16'h0002); push_word(16'h0003);
    check("full_count", tx_count, 4);
    check("full_flag",  cpu_full, 1);
    check("full_head",  tx_data,  16'hAAAA);
    cpu_we = 1; cpu_wdata = 16'hBBBB; tx_ready = 1;
    tick();
    cpu_we = 0;
    check("pp_count", tx_count, 4);
    check("pp_err",   err,      2'b00);
    check("pp_head",  tx_data,  16'h0001);
    exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'hBBBB};
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      if (tx_valid) check("pp_order", tx_data, exp_q.pop_front());
      tick();
    end
    check("pp_drained", exp_q.size(), 0);
    check("pp_empty",   tx_valid,     0);
    tx_ready = 0;

    // Underflow, then err_clr together with a new overflow
    cpu_re = 1; tick(); cpu_re = 0;
    check("unf_err",      err,        2'b10);
    check("unf_rvalid",   cpu_rvalid, 0);
    check("unf_rx_ready", rx_ready,   1);
    push_word(16'h0010); push_word(16'h0020); push_word(16'h0030); push_word(16'h0040);
    cpu_we = 1; cpu_wdata = 16'h5555; err_clr = 1;
    tick();
    cpu_we = 0; err_clr = 0;
    check("clr_ovf_err",   err,      2'b01);
    check("clr_ovf_count", tx_count, 4);

    // Reset mid-operation
    rst = 1; tick(); rst = 0;
    push_word(16'h0A0A); push_word(16'h0B0B);
    cpu_we = 1; cpu_wdata = 16'h0C0C; rx_valid = 1; rx_data = 16'h1234;
    tick();
    cpu_we = 0; rx_valid = 0;
    check("mid_count",  tx_count,   3);
    check("mid_rvalid", cpu_rvalid, 1);
    rst = 1; tx_ready = 1; cpu_we = 1; cpu_wdata = 16'h0D0D;
    tick();
    rst = 0; cpu_we = 0;
    check("mrst_count",    tx_count,   0);
    check("mrst_valid",    tx_valid,   0);
    check("mrst_rvalid",   cpu_rvalid, 0);
    check("mrst_rx_ready", rx_ready,   1);
    check("mrst_rdata",    cpu_rdata,  16'h0000);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("mrst_no_emit", tx_valid, 0);
    end
    idle_inputs();

    // Randomized traffic against the reference model
    m_q.delete();
    m_rx_full = 0; m_rdata = 16'h0000; m_err = 2'b00;
    for (int c = 0; c < 400; c++) begin
      int bias;
      bias      = (c < 200) ? 30 : 70;
      cpu_we    = ($urandom_range(0, 99) < 55);
      cpu_wdata = 16'($urandom);
      tx_ready  = ($urandom_range(0, 99) < bias);
      rx_valid  = ($urandom_range(0, 99) < 50);
      rx_data   = 16'($urandom);
      cpu_re    = ($urandom_range(0, 99) < 45);
      err_clr   = ($urandom_range(0, 99) < 10);
      model_step();
      tick();
      check("rnd_count",    tx_count,   m_q.size());
      check("rnd_full",     cpu_full,   (m_q.size() == 4));
      check("rnd_valid",    tx_valid,   (m_q.size() > 0));
      if (m_q.size() > 0) check("rnd_tx_data", tx_data, m_q[0]);
      check("rnd_rvalid",   cpu_rvalid, m_rx_full);
      check("rnd_rx_ready", rx_ready,   !m_rx_full);
      check("rnd_rdata",    cpu_rdata,  m_rdata);
      check("rnd_err",      err,        m_err);
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
